l1d_data_pipe_evict_seq: RTL and testbench

Next-generation eviction sequencer for the L1D data pipe. It accepts evict requests from N_SRC MSHR banks, queues them in an EVQ_DEPTH-entry FIFO, and expands each request into BEATS data-RAM read beats toward the data-pipe arbiter. Beat issue is gated by a real credit counter for the write adapter. On each line's last beat it emits a data-RAM clean pulse carrying the evict id.

---
 rtl/l1d_data_pipe_evict_seq_pkg.sv | 33 +++
 rtl/l1d_data_pipe_evict_seq_if.sv | 34 +++
 rtl/l1d_data_pipe_evict_seq_rr_arb.sv | 36 +++
 rtl/l1d_data_pipe_evict_seq.sv | 95 +++++++++
 tb/tb_l1d_data_pipe_evict_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1d_data_pipe_evict_seq_pkg.sv
// l1d_data_pipe_evict_seq_pkg: shared L1D widths and payload types for the eviction sequencer
package l1d_data_pipe_evict_seq_pkg;
    localparam int L1D_OFFSET_WIDTH  = 2;
    localparam int L1D_OFFSET_MAX    = (1 << L1D_OFFSET_WIDTH) - 1;
    localparam int L1D_INDEX_WIDTH   = 6;
    localparam int L1D_WAY_WIDTH     = 2;
    localparam int L1D_MSHR_ID_WIDTH = 4;
    localparam int BEATS             = L1D_OFFSET_MAX + 1;

    typedef struct packed {
        logic [L1D_INDEX_WIDTH-1:0]   index;
        logic [L1D_WAY_WIDTH-1:0]     way;
        logic [L1D_OFFSET_WIDTH-1:0]  offset;
        logic [L1D_MSHR_ID_WIDTH-1:0] mshr_id;
    } pack_evict_req_pld;

    typedef struct packed {
        logic [L1D_INDEX_WIDTH-1:0]  index;
        logic [L1D_WAY_WIDTH-1:0]    way;
        logic [L1D_OFFSET_WIDTH-1:0] offset;
    } pack_evict_dat_addr;

    typedef struct packed {
        pack_evict_dat_addr           evict_dat_addr;
        logic [L1D_MSHR_ID_WIDTH-1:0] evict_id;
    } pack_evict_dat_pld;

    typedef struct packed {
        logic [L1D_INDEX_WIDTH-1:0]   index;
        logic [L1D_WAY_WIDTH-1:0]     way;
        logic [L1D_MSHR_ID_WIDTH-1:0] mshr_id;
    } pack_evq_entry;
endpackage

// File: rtl/l1d_data_pipe_evict_seq_if.sv
// l1d_data_pipe_evict_seq_if: request, beat, clean and credit signals of the eviction sequencer
interface l1d_data_pipe_evict_seq_if
    import l1d_data_pipe_evict_seq_pkg::*;
#(
    parameter int N_SRC   = 2,
    parameter int CRD_MAX = 8,
    parameter int CRD_W   = $clog2(CRD_MAX + 1)
);
    logic [N_SRC-1:0]             evict_req_vld;
    logic [N_SRC-1:0]             evict_req_rdy;
    pack_evict_req_pld [N_SRC-1:0] evict_req_pld;
    logic                         evict_dat_vld;
    logic                         evict_dat_rdy;
    pack_evict_dat_pld            evict_dat_pld;
    logic                         evict_dat_last;
    logic                         evict_dat_ram_clean_en;
    logic [L1D_MSHR_ID_WIDTH-1:0] evict_dat_ram_clean_id;
    logic                         adp_crd_rtn;
    logic [CRD_W-1:0]             crd_cnt;
    logic                         evq_busy;
    logic                         crd_ovf_err;

    modport master (
        output evict_req_vld, evict_req_pld, evict_dat_rdy, adp_crd_rtn,
        input  evict_req_rdy, evict_dat_vld, evict_dat_pld, evict_dat_last,
               evict_dat_ram_clean_en, evict_dat_ram_clean_id, crd_cnt, evq_busy, crd_ovf_err
    );

    modport slave (
        input  evict_req_vld, evict_req_pld, evict_dat_rdy, adp_crd_rtn,
        output evict_req_rdy, evict_dat_vld, evict_dat_pld, evict_dat_last,
               evict_dat_ram_clean_en, evict_dat_ram_clean_id, crd_cnt, evq_busy, crd_ovf_err
    );
endinterface

// File: rtl/l1d_data_pipe_evict_seq_rr_arb.sv
// l1d_rr_arb: round-robin one-hot arbiter; pointer moves past the winner only on accept
module l1d_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);
    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, gidx, j;

    // scan from the highest offset down so the requester nearest the pointer wins
    always_comb begin
        grant = '0;
        gidx  = ptr_q;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(ptr_q) + k) % N);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = j;
            end
        end
        ptr_d = accept ? ((gidx == PW'(N - 1)) ? '0 : gidx + PW'(1)) : ptr_q;
    end

    // priority pointer register
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/l1d_data_pipe_evict_seq.sv
// l1d_data_pipe_evict_seq: queues MSHR evictions and expands each into credit-gated data-RAM read beats
module l1d_data_pipe_evict_seq
    import l1d_data_pipe_evict_seq_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int EVQ_DEPTH = 4,
    parameter int CRD_MAX   = 8,
    parameter int CRD_W     = $clog2(CRD_MAX + 1)
) (
    input logic                    clk,
    input logic                    rst,
    l1d_data_pipe_evict_seq_if.slave bus
);
    localparam int AW  = $clog2(EVQ_DEPTH);
    localparam int PW1 = AW + 1;

    logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    pack_evq_entry [EVQ_DEPTH-1:0] mem_q, mem_d;
    logic [L1D_OFFSET_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CRD_W-1:0]             crd_q, crd_d;
    logic                         ovf_q, ovf_d, clean_en_q, clean_en_d;
    logic [L1D_MSHR_ID_WIDTH-1:0] clean_id_q, clean_id_d;
    logic [N_SRC-1:0]             grant;
    logic                         empty, full, push, pop, hs, vld, last, sat;
    pack_evq_entry                head, in_ent;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign push  = !full && |grant;

    l1d_rr_arb #(.N(N_SRC)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.evict_req_vld),
        .accept (push),
        .grant  (grant)
    );

    // queue, beat and credit next-state; request offset is dropped since lines restart at beat 0
    always_comb begin
        in_ent = '0;
        for (int i = 0; i < N_SRC; i++)
            if (grant[i]) in_ent = '{index:   bus.evict_req_pld[i].index,
                                     way:     bus.evict_req_pld[i].way,
                                     mshr_id: bus.evict_req_pld[i].mshr_id};
        head       = mem_q[rd_ptr_q[AW-1:0]];
        vld        = !empty && (crd_q != '0);
        hs         = vld && bus.evict_dat_rdy;
        last       = beat_cnt_q == L1D_OFFSET_WIDTH'(BEATS - 1);
        pop        = hs && last;
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = in_ent;
        wr_ptr_d   = wr_ptr_q + PW1'(push);
        rd_ptr_d   = rd_ptr_q + PW1'(pop);
        beat_cnt_d = beat_cnt_q + L1D_OFFSET_WIDTH'(hs);
        sat        = bus.adp_crd_rtn && !hs && (crd_q == CRD_W'(CRD_MAX));
        crd_d      = sat ? crd_q : crd_q + CRD_W'(bus.adp_crd_rtn) - CRD_W'(hs);
        ovf_d      = ovf_q || sat;
        clean_en_d = pop;
        clean_id_d = pop ? head.mshr_id : clean_id_q;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '0;
            beat_cnt_q <= '0;
            crd_q      <= CRD_W'(CRD_MAX);
            ovf_q      <= 1'b0;
            clean_en_q <= 1'b0;
            clean_id_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
            beat_cnt_q <= beat_cnt_d;
            crd_q      <= crd_d;
            ovf_q      <= ovf_d;
            clean_en_q <= clean_en_d;
            clean_id_q <= clean_id_d;
        end
    end

    assign bus.evict_req_rdy          = full ? '0 : grant;
    assign bus.evict_dat_vld          = vld;
    assign bus.evict_dat_pld          = {head.index, head.way, beat_cnt_q, head.mshr_id};
    assign bus.evict_dat_last         = last;
    assign bus.evict_dat_ram_clean_en = clean_en_q;
    assign bus.evict_dat_ram_clean_id = clean_id_q;
    assign bus.crd_cnt                = crd_q;
    assign bus.evq_busy               = !empty;
    assign bus.crd_ovf_err            = ovf_q;
endmodule

// File: tb/tb_l1d_data_pipe_evict_seq.sv
// tb_l1d_data_pipe_evict_seq: directed scenarios for the eviction sequencer (8-credit and 2-credit instances)
module tb_l1d_data_pipe_evict_seq;
    import l1d_data_pipe_evict_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    l1d_data_pipe_evict_seq_if #(.N_SRC(2), .CRD_MAX(8)) b0();
    l1d_data_pipe_evict_seq_if #(.N_SRC(2), .CRD_MAX(2)) b1();

    l1d_data_pipe_evict_seq #(.N_SRC(2), .EVQ_DEPTH(4), .CRD_MAX(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
    l1d_data_pipe_evict_seq #(.N_SRC(2), .EVQ_DEPTH(4), .CRD_MAX(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

    function automatic pack_evict_req_pld req(int idx, int way, int off, int id);
        return {L1D_INDEX_WIDTH'(idx), L1D_WAY_WIDTH'(way), L1D_OFFSET_WIDTH'(off), L1D_MSHR_ID_WIDTH'(id)};
    endfunction

    function automatic pack_evict_dat_pld dat(int idx, int way, int off, int id);
        return {L1D_INDEX_WIDTH'(idx), L1D_WAY_WIDTH'(way), L1D_OFFSET_WIDTH'(off), L1D_MSHR_ID_WIDTH'(id)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.evict_req_vld = '0; b0.evict_req_pld = '0; b0.evict_dat_rdy = 1'b0; b0.adp_crd_rtn = 1'b0;
        b1.evict_req_vld = '0; b1.evict_req_pld = '0; b1.evict_dat_rdy = 1'b0; b1.adp_crd_rtn = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (b0.evict_dat_vld !== 1'b0) begin errs++; $display("FAIL reset_vld got=%0b exp=0", b0.evict_dat_vld); end
        checks++; if (b0.crd_cnt !== 4'd8) begin errs++; $display("FAIL reset_crd got=%0d exp=8", b0.crd_cnt); end
        checks++; if (b1.crd_cnt !== 2'd2) begin errs++; $display("FAIL reset_crd2 got=%0d exp=2", b1.crd_cnt); end
        checks++; if (b0.evq_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0b exp=0", b0.evq_busy); end
        checks++; if (b0.evict_dat_ram_clean_en !== 1'b0) begin errs++; $display("FAIL reset_clean got=%0b exp=0", b0.evict_dat_ram_clean_en); end
        checks++; if (b0.crd_ovf_err !== 1'b0) begin errs++; $display("FAIL reset_ovf got=%0b exp=0", b0.crd_ovf_err); end
        checks++; if (b0.evict_req_rdy !== 2'b00) begin errs++; $display("FAIL reset_rdy got=%b exp=00", b0.evict_req_rdy); end
        checks++; if (b0.evict_dat_last !== 1'b0) begin errs++; $display("FAIL reset_last got=%0b exp=0", b0.evict_dat_last); end
        step();
    endtask

    task automatic test_single_line();
        do_reset();
        b0.evict_req_pld[0] = req(5, 2, 1, 3);
        b0.evict_req_vld = 2'b01;
        b0.evict_dat_rdy = 1'b1;
        @(negedge clk);
        checks++; if (b0.evict_req_rdy !== 2'b01) begin errs++; $display("FAIL single_rdy got=%b exp=01", b0.evict_req_rdy); end
        checks++; if (b0.evict_dat_vld !== 1'b0) begin errs++; $display("FAIL single_nobypass got=%0b exp=0", b0.evict_dat_vld); end
        step();
        b0.evict_req_vld = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (b0.evict_dat_vld !== 1'b1) begin errs++; $display("FAIL single_vld beat=%0d got=%0b exp=1", k, b0.evict_dat_vld); end
            checks++; if (b0.evict_dat_pld !== dat(5, 2, k, 3)) begin errs++; $display("FAIL single_pld beat=%0d got=%h exp=%h", k, b0.evict_dat_pld, dat(5, 2, k, 3)); end
            checks++; if (b0.evict_dat_last !== (k == 3)) begin errs++; $display("FAIL single_last beat=%0d got=%0b", k, b0.evict_dat_last); end
            step();
        end
        @(negedge clk);
        checks++; if (b0.evict_dat_ram_clean_en !== 1'b1) begin errs++; $display("FAIL single_clean_en got=%0b exp=1", b0.evict_dat_ram_clean_en); end
        checks++; if (b0.evict_dat_ram_clean_id !== 4'd3) begin errs++; $display("FAIL single_clean_id got=%0d exp=3", b0.evict_dat_ram_clean_id); end
        checks++; if (b0.crd_cnt !== 4'd4) begin errs++; $display("FAIL single_crd got=%0d exp=4", b0.crd_cnt); end
        checks++; if (b0.evq_busy !== 1'b0 || b0.evict_dat_vld !== 1'b0) begin errs++; $display("FAIL single_idle busy=%0b vld=%0b exp=0,0", b0.evq_busy, b0.evict_dat_vld); end
        step();
        @(negedge clk);
        checks++; if (b0.evict_dat_ram_clean_en !== 1'b0) begin errs++; $display("FAIL single_clean_pulse got=%0b exp=0", b0.evict_dat_ram_clean_en); end
        step();
    endtask

    task automatic test_credit_starve();
        do_reset();
        b1.evict_req_pld[1] = req(9, 1, 0, 7);
        b1.evict_req_vld = 2'b10;
        b1.evict_dat_rdy = 1'b1;
        step();
        b1.evict_req_vld = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (b1.evict_dat_vld !== 1'b1 || b1.evict_dat_pld !== dat(9, 1, k, 7)) begin errs++; $display("FAIL starve_beat%0d vld=%0b pld=%h exp=1,%h", k, b1.evict_dat_vld, b1.evict_dat_pld, dat(9, 1, k, 7)); end
            step();
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            checks++; if (b1.evict_dat_vld !== 1'b0) begin errs++; $display("FAIL starve_stall%0d vld got=%0b exp=0", s, b1.evict_dat_vld); end
            checks++; if (b1.evict_dat_pld !== dat(9, 1, 2, 7)) begin errs++; $display("FAIL starve_hold%0d pld got=%h exp=%h", s, b1.evict_dat_pld, dat(9, 1, 2, 7)); end
            checks++; if (b1.crd_cnt !== 2'd0) begin errs++; $display("FAIL starve_crd%0d got=%0d exp=0", s, b1.crd_cnt); end
            step();
        end
        b1.adp_crd_rtn = 1'b1;
        @(negedge clk);
        checks++; if (b1.evict_dat_vld !== 1'b0) begin errs++; $display("FAIL starve_rtn_cycle vld got=%0b exp=0", b1.evict_dat_vld); end
        step();
        b1.adp_crd_rtn = 1'b0;
        @(negedge clk);
        checks++; if (b1.evict_dat_vld !== 1'b1 || b1.evict_dat_pld !== dat(9, 1, 2, 7)) begin errs++; $display("FAIL starve_resume vld=%0b pld=%h exp=1,%h", b1.evict_dat_vld, b1.evict_dat_pld, dat(9, 1, 2, 7)); end
        step();
        @(negedge clk);
        checks++; if (b1.evict_dat_vld !== 1'b0 || b1.evict_dat_pld !== dat(9, 1, 3, 7)) begin errs++; $display("FAIL starve_stall3 vld=%0b pld=%h exp=0,%h", b1.evict_dat_vld, b1.evict_dat_pld, dat(9, 1, 3, 7)); end
        b1.adp_crd_rtn = 1'b1;
        step();
        b1.adp_crd_rtn = 1'b0;
        @(negedge clk);
        checks++; if (b1.evict_dat_vld !== 1'b1 || b1.evict_dat_last !== 1'b1) begin errs++; $display("FAIL starve_last vld=%0b last=%0b exp=1,1", b1.evict_dat_vld, b1.evict_dat_last); end
        step();
        @(negedge clk);
        checks++; if (b1.evict_dat_ram_clean_en !== 1'b1 || b1.evict_dat_ram_clean_id !== 4'd7) begin errs++; $display("FAIL starve_clean en=%0b id=%0d exp=1,7", b1.evict_dat_ram_clean_en, b1.evict_dat_ram_clean_id); end
        step();
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_rdy [5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        int exp_id [4] = '{1, 2, 1, 1};
        int n = 0;
        do_reset();
        b0.evict_req_pld[0] = req(1, 0, 0, 1);
        b0.evict_req_pld[1] = req(2, 1, 0, 2);
        b0.evict_req_vld = 2'b11;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) b0.evict_req_vld = 2'b01;
            @(negedge clk);
            checks++; if (b0.evict_req_rdy !== exp_rdy[i]) begin errs++; $display("FAIL rr_rdy%0d got=%b exp=%b", i, b0.evict_req_rdy, exp_rdy[i]); end
            step();
        end
        b0.evict_req_vld = '0;
        b0.evict_dat_rdy = 1'b1;
        b0.adp_crd_rtn = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (b0.evict_dat_ram_clean_en === 1'b1) begin
                checks++; if (b0.evict_dat_ram_clean_id !== 4'(exp_id[n])) begin errs++; $display("FAIL rr_order%0d got=%0d exp=%0d", n, b0.evict_dat_ram_clean_id, exp_id[n]); end
                n++;
            end
            step();
        end
        b0.adp_crd_rtn = 1'b0;
        checks++; if (n != 4) begin errs++; $display("FAIL rr_drain_timeout lines=%0d exp=4", n); end
    endtask

    task automatic test_backpressure();
        int line = 0, beat = 0, pulses = 0;
        logic prev_stall = 1'b0;
        pack_evict_dat_pld prev_pld = '0;
        do_reset();
        b0.evict_req_vld = 2'b10;
        for (int i = 0; i < 4; i++) begin
            b0.evict_req_pld[1] = req(20 + i, i, 0, 10 + i);
            step();
        end
        b0.evict_req_vld = '0;
        for (int c = 0; c < 60 && pulses < 4; c++) begin
            b0.evict_dat_rdy = (c % 2) == 0;
            b0.adp_crd_rtn = (c % 2) == 0;
            @(negedge clk);
            if (prev_stall) begin
                checks++; if (b0.evict_dat_vld !== 1'b1 || b0.evict_dat_pld !== prev_pld) begin errs++; $display("FAIL bp_hold c=%0d vld=%0b pld=%h exp=1,%h", c, b0.evict_dat_vld, b0.evict_dat_pld, prev_pld); end
            end
            if (b0.evict_dat_vld === 1'b1 && line < 4) begin
                checks++; if (b0.evict_dat_pld !== dat(20 + line, line, beat, 10 + line)) begin errs++; $display("FAIL bp_pld c=%0d got=%h exp=%h", c, b0.evict_dat_pld, dat(20 + line, line, beat, 10 + line)); end
            end
            if (b0.evict_dat_ram_clean_en === 1'b1) begin
                checks++; if (b0.evict_dat_ram_clean_id !== 4'(10 + pulses)) begin errs++; $display("FAIL bp_clean%0d got=%0d exp=%0d", pulses, b0.evict_dat_ram_clean_id, 10 + pulses); end
                pulses++;
            end
            prev_stall = b0.evict_dat_vld === 1'b1 && !b0.evict_dat_rdy;
            prev_pld = b0.evict_dat_pld;
            if (b0.evict_dat_vld === 1'b1 && b0.evict_dat_rdy) begin
                beat++;
                if (beat == 4) begin beat = 0; line++; end
            end
            step();
        end
        b0.evict_dat_rdy = 1'b0;
        b0.adp_crd_rtn = 1'b0;
        checks++; if (pulses != 4 || line != 4) begin errs++; $display("FAIL bp_timeout pulses=%0d lines=%0d exp=4,4", pulses, line); end
    endtask

    task automatic test_credit_arith();
        do_reset();
        b0.evict_req_pld[0] = req(3, 0, 0, 4);
        b0.evict_req_vld = 2'b01;
        b0.evict_dat_rdy = 1'b1;
        step();
        b0.evict_req_pld[0] = req(4, 1, 0, 5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (b0.evict_dat_vld !== 1'b1 || b0.crd_cnt !== 4'(k <= 5 ? 8 - k : 9 - k)) begin errs++; $display("FAIL crd_beat%0d vld=%0b crd=%0d exp=1,%0d", k, b0.evict_dat_vld, b0.crd_cnt, k <= 5 ? 8 - k : 9 - k); end
            b0.adp_crd_rtn = k == 5;
            step();
            if (k == 0) b0.evict_req_vld = '0;
        end
        b0.adp_crd_rtn = 1'b0;
        @(negedge clk);
        checks++; if (b0.crd_cnt !== 4'd1) begin errs++; $display("FAIL crd_after got=%0d exp=1", b0.crd_cnt); end
        b0.adp_crd_rtn = 1'b1;
        for (int i = 0; i < 7; i++) step();
        @(negedge clk);
        checks++; if (b0.crd_cnt !== 4'd8 || b0.crd_ovf_err !== 1'b0) begin errs++; $display("FAIL crd_full crd=%0d ovf=%0b exp=8,0", b0.crd_cnt, b0.crd_ovf_err); end
        step();
        b0.adp_crd_rtn = 1'b0;
        @(negedge clk);
        checks++; if (b0.crd_cnt !== 4'd8 || b0.crd_ovf_err !== 1'b1) begin errs++; $display("FAIL crd_sat crd=%0d ovf=%0b exp=8,1", b0.crd_cnt, b0.crd_ovf_err); end
        step();
        step();
        @(negedge clk);
        checks++; if (b0.crd_ovf_err !== 1'b1) begin errs++; $display("FAIL crd_ovf_sticky got=%0b exp=1", b0.crd_ovf_err); end
        do_reset();
        @(negedge clk);
        checks++; if (b0.crd_ovf_err !== 1'b0) begin errs++; $display("FAIL crd_ovf_clear got=%0b exp=0", b0.crd_ovf_err); end
        step();
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        b0.evict_req_pld[0] = req(6, 3, 0, 9);
        b0.evict_req_vld = 2'b01;
        b0.evict_dat_rdy = 1'b1;
        step();
        b0.evict_req_vld = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (b0.evict_dat_pld !== dat(6, 3, k, 9)) begin errs++; $display("FAIL mid_beat%0d got=%h exp=%h", k, b0.evict_dat_pld, dat(6, 3, k, 9)); end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (b0.evict_dat_vld !== 1'b0 || b0.evict_dat_ram_clean_en !== 1'b0) begin errs++; $display("FAIL mid_rst_out vld=%0b clean=%0b exp=0,0", b0.evict_dat_vld, b0.evict_dat_ram_clean_en); end
        checks++; if (b0.crd_cnt !== 4'd8 || b0.evq_busy !== 1'b0) begin errs++; $display("FAIL mid_rst_state crd=%0d busy=%0b exp=8,0", b0.crd_cnt, b0.evq_busy); end
        step();
        b0.evict_req_pld[0] = req(7, 0, 2, 11);
        b0.evict_req_vld = 2'b01;
        step();
        b0.evict_req_vld = '0;
        @(negedge clk);
        checks++; if (b0.evict_dat_vld !== 1'b1 || b0.evict_dat_pld !== dat(7, 0, 0, 11)) begin errs++; $display("FAIL mid_restart vld=%0b pld=%h exp=1,%h", b0.evict_dat_vld, b0.evict_dat_pld, dat(7, 0, 0, 11)); end
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_line();
        test_credit_starve();
        test_rr_fairness();
        test_backpressure();
        test_credit_arith();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
